// File: rtl/multi_cycle_control_unit_if.sv
// Control/status bundle between the multi-cycle control unit (master) and the RV32I datapath (slave).
interface multi_cycle_control_unit_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       bcond;
  logic       halt_req;

  logic       pc_write;
  logic [1:0] pc_source;
  logic       npc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       mem_to_reg;
  logic       pc_to_reg;
  logic       instr_done;
  logic       is_halted;

  modport master (
    input  opcode, mem_ready, bcond, halt_req,
    output pc_write, pc_source, npc_write, i_or_d, mem_read, mem_write,
           ir_write, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           pc_to_reg, instr_done, is_halted
  );

  modport slave (
    output opcode, mem_ready, bcond, halt_req,
    input  pc_write, pc_source, npc_write, i_or_d, mem_read, mem_write,
           ir_write, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           pc_to_reg, instr_done, is_halted
  );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// IF/ID/EX/MEM/WB sequencer for the multi-cycle RV32I core with ready-handshake memory.
// Define ECALL_HALT_EN to let ECALL with halt_req park the core in HALT until reset.
module multi_cycle_control_unit (
  input  logic                              clk,
  input  logic                              reset_n,
  multi_cycle_control_unit_if.master        bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_ARITH_I = 7'b0010011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_ARITH   = 7'b0110011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_ECALL   = 7'b1110011;

  state_e     state_q, state_d;
  logic       run_q, run_d;

  logic       npc_write_q, npc_write_d;
  logic       i_or_d_q, i_or_d_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic       pc_to_reg_q, pc_to_reg_d;

  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       instr_done;

  logic       op_load, op_store, op_alu, op_known;
  logic       halt_take;

  assign op_load  = (bus.opcode == OP_LOAD);
  assign op_store = (bus.opcode == OP_STORE);
  assign op_alu   = (bus.opcode == OP_ARITH) || (bus.opcode == OP_ARITH_I);
  assign op_known = op_load || op_store || op_alu ||
                    (bus.opcode == OP_BRANCH) || (bus.opcode == OP_JAL) ||
                    (bus.opcode == OP_JALR);

`ifdef ECALL_HALT_EN
  assign halt_take     = (bus.opcode == OP_ECALL) && bus.halt_req;
  assign bus.is_halted = (state_q == S_HALT);
`else
  logic halt_req_unused;
  assign halt_req_unused = bus.halt_req;
  assign halt_take       = 1'b0;
  assign bus.is_halted   = 1'b0;
`endif

  // run_q holds the FSM idle for the partial cycle between reset release and the first edge.
  always_comb begin
    run_d   = 1'b1;
    state_d = state_q;
    if (run_q) begin
      unique case (state_q)
        S_IF:   if (bus.mem_ready) state_d = S_ID;
        S_ID: begin
          if (halt_take)     state_d = S_HALT;
          else if (op_known) state_d = S_EX;
          else               state_d = S_IF;
        end
        S_EX: begin
          if (op_load || op_store) state_d = S_MEM;
          else if (op_alu)         state_d = S_WB;
          else                     state_d = S_IF;
        end
        S_MEM:  if (bus.mem_ready) state_d = op_load ? S_WB : S_IF;
        S_WB:   state_d = S_IF;
        S_HALT: state_d = S_HALT;
        default: state_d = S_IF;
      endcase
    end
  end

  // Opcode-only outputs are registered from the next state; IR is stable from ID onward.
  always_comb begin
    npc_write_d  = 1'b0;
    i_or_d_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 2'd0;
    alu_op_d     = 2'd0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    pc_to_reg_d  = 1'b0;
    unique case (state_d)
      S_IF: mem_read_d = 1'b1;
      S_ID: begin
        npc_write_d = 1'b1;
        alu_src_b_d = 2'd1;
      end
      S_EX: begin
        unique case (bus.opcode)
          OP_ARITH: begin
            alu_src_a_d = 1'b1;
            alu_op_d    = 2'd2;
          end
          OP_ARITH_I: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = 2'd2;
            alu_op_d    = 2'd2;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = 2'd2;
          end
          OP_BRANCH: begin
            alu_src_a_d = 1'b1;
            alu_op_d    = 2'd1;
          end
          OP_JAL: begin
            reg_write_d = 1'b1;
            pc_to_reg_d = 1'b1;
          end
          OP_JALR: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = 2'd2;
            reg_write_d = 1'b1;
            pc_to_reg_d = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        i_or_d_d    = 1'b1;
        mem_read_d  = op_load;
        mem_write_d = op_store;
      end
      S_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = op_load;
      end
      default: ;
    endcase
  end

  // Outputs that react to mem_ready, bcond or the freshly decoded opcode in the same cycle.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'd0;
    instr_done = 1'b0;
    unique case (state_q)
      S_IF: ir_write = run_q && bus.mem_ready;
      S_ID: begin
        if (!halt_take && !op_known) begin
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_EX: begin
        unique case (bus.opcode)
          OP_BRANCH: begin
            pc_write   = 1'b1;
            pc_source  = bus.bcond ? 2'd2 : 2'd1;
            instr_done = 1'b1;
          end
          OP_JAL: begin
            pc_write   = 1'b1;
            pc_source  = 2'd2;
            instr_done = 1'b1;
          end
          OP_JALR: begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready && op_store) begin
          pc_write   = 1'b1;
          pc_source  = 2'd1;
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        pc_write   = 1'b1;
        pc_source  = 2'd1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IF;
      run_q        <= 1'b0;
      npc_write_q  <= 1'b0;
      i_or_d_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= '0;
      alu_op_q     <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pc_to_reg_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      npc_write_q  <= npc_write_d;
      i_or_d_q     <= i_or_d_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_op_q     <= alu_op_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      pc_to_reg_q  <= pc_to_reg_d;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.pc_source  = pc_source;
  assign bus.ir_write   = ir_write;
  assign bus.instr_done = instr_done;
  assign bus.npc_write  = npc_write_q;
  assign bus.i_or_d     = i_or_d_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.alu_src_a  = alu_src_a_q;
  assign bus.alu_src_b  = alu_src_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.mem_to_reg = mem_to_reg_q;
  assign bus.pc_to_reg  = pc_to_reg_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed + randomized bench: per-instruction expected control traces built from the phase rules.
module tb_multi_cycle_control_unit;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_ARITH_I = 7'b0010011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_ARITH   = 7'b0110011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_ECALL   = 7'b1110011;
  localparam logic [6:0] OP_ZERO    = 7'b0000000;
  localparam logic [6:0] OP_FENCE   = 7'b0001111;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       npc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       instr_done;
    logic       is_halted;
  } ov_t;

  typedef struct {
    ov_t        e;
    logic       rdy;
    logic       bc;
    logic       hr;
    logic [6:0] op;
  } step_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  step_t q[$];
  ov_t  obs;

  multi_cycle_control_unit_if bus ();

  multi_cycle_control_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always_comb obs = {bus.pc_write, bus.pc_source, bus.npc_write, bus.i_or_d,
                     bus.mem_read, bus.mem_write, bus.ir_write, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_op, bus.reg_write, bus.mem_to_reg,
                     bus.pc_to_reg, bus.instr_done, bus.is_halted};

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic check(input string tag, input ov_t exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input ov_t e, input logic rdy, input logic bc, input logic hr, input logic [6:0] op);
    step_t s;
    s.e = e; s.rdy = rdy; s.bc = bc; s.hr = hr; s.op = op;
    q.push_back(s);
  endtask

  // Latency from the zero-wait table plus every memory wait cycle.
  function automatic int latency(input logic [6:0] op, input int unsigned w_if, input int unsigned w_mem);
    int base;
    case (op)
      OP_ARITH, OP_ARITH_I:       base = 4;
      OP_LOAD:                    base = 5 + int'(w_mem);
      OP_STORE:                   base = 4 + int'(w_mem);
      OP_BRANCH, OP_JAL, OP_JALR: base = 3;
      default:                    base = 2;
    endcase
    return base + int'(w_if);
  endfunction

  task automatic build(input logic [6:0] op, input int unsigned w_if, input int unsigned w_mem,
                       input logic bc, input logic hr);
    ov_t  e;
    logic ld, st, known, halt;
    ld    = (op == OP_LOAD);
    st    = (op == OP_STORE);
    known = op inside {OP_ARITH, OP_ARITH_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
`ifdef ECALL_HALT_EN
    halt  = (op == OP_ECALL) && hr;
`else
    halt  = 1'b0;
`endif
    for (int unsigned i = 0; i < w_if; i++) begin
      e = '0; e.mem_read = 1'b1;
      push(e, 1'b0, rb(), rb(), 7'($urandom));
    end
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
    push(e, 1'b1, rb(), rb(), 7'($urandom));
    e = '0; e.npc_write = 1'b1; e.alu_src_b = 2'd1;
    if (!halt && !known) begin e.pc_write = 1'b1; e.instr_done = 1'b1; end
    push(e, rb(), rb(), hr, op);
    if (halt) begin
      for (int unsigned i = 0; i < 12; i++) begin
        e = '0; e.is_halted = 1'b1;
        push(e, rb(), rb(), rb(), 7'($urandom));
      end
    end
    if (halt || !known) return;
    e = '0;
    case (op)
      OP_ARITH:   begin e.alu_src_a = 1'b1; e.alu_op = 2'd2; end
      OP_ARITH_I: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 2'd2; end
      OP_LOAD, OP_STORE: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
      OP_BRANCH: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_write = 1'b1;
        e.pc_source = bc ? 2'd2 : 2'd1; e.instr_done = 1'b1;
      end
      OP_JAL: begin
        e.reg_write = 1'b1; e.pc_to_reg = 1'b1; e.pc_write = 1'b1;
        e.pc_source = 2'd2; e.instr_done = 1'b1;
      end
      OP_JALR: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.reg_write = 1'b1; e.pc_to_reg = 1'b1;
        e.pc_write = 1'b1; e.pc_source = 2'd0; e.instr_done = 1'b1;
      end
      default: ;
    endcase
    push(e, rb(), bc, rb(), op);
    if (ld || st) begin
      for (int unsigned i = 0; i < w_mem; i++) begin
        e = '0; e.i_or_d = 1'b1; e.mem_read = ld; e.mem_write = st;
        push(e, 1'b0, rb(), rb(), op);
      end
      e = '0; e.i_or_d = 1'b1; e.mem_read = ld; e.mem_write = st;
      e.pc_write = st; e.pc_source = st ? 2'd1 : 2'd0; e.instr_done = st;
      push(e, 1'b1, rb(), rb(), op);
    end
    if (ld || op == OP_ARITH || op == OP_ARITH_I) begin
      e = '0; e.reg_write = 1'b1; e.mem_to_reg = ld;
      e.pc_write = 1'b1; e.pc_source = 2'd1; e.instr_done = 1'b1;
      push(e, rb(), rb(), rb(), op);
    end
  endtask

  // exp_lat > 0: one instr_done on that cycle; 0: none expected; < 0: not checked.
  task automatic exec(input string tag, input int unsigned n_max, input int exp_lat);
    step_t s;
    int unsigned cyc, done_cnt, done_at;
    cyc = 0; done_cnt = 0; done_at = 0;
    while (q.size() != 0 && cyc < n_max) begin
      s = q.pop_front();
      @(posedge clk);
      #1;
      bus.opcode = s.op; bus.mem_ready = s.rdy; bus.bcond = s.bc; bus.halt_req = s.hr;
      #3;
      cyc++;
      check($sformatf("%s_c%0d", tag, cyc), s.e);
      if (obs.instr_done === 1'b1) begin done_cnt++; done_at = cyc; end
    end
    q.delete();
    if (exp_lat >= 0) begin
      total++;
      assert (done_cnt == ((exp_lat > 0) ? 1 : 0) && (exp_lat == 0 || int'(done_at) == exp_lat)) else begin
        bad++;
        $error("FAIL %s_latency obs=%0d/%0d exp=%0d", tag, done_cnt, done_at, exp_lat);
      end
    end
  endtask

  task automatic reset_now(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_async"}, '0);
    repeat (2) @(posedge clk);
    bus.mem_ready = rb(); bus.opcode = 7'($urandom);
    #2;
    check({tag, "_hold"}, '0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [6:0] ops[10];
    logic [6:0] op;
    int unsigned wi, wm;
    logic bc, hr;
    ops = '{OP_ARITH, OP_ARITH_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_ECALL, OP_ZERO, OP_FENCE};
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.bcond = 1'b0; bus.halt_req = 1'b0;

    #2 check("reset_init", '0);
    @(negedge clk);
    reset_now("reset");

    build(OP_ARITH, 0, 0, 1'b0, 1'b0);   exec("add", 100, 4);
    build(OP_LOAD, 2, 2, 1'b0, 1'b0);    exec("load_wait", 100, 9);
    build(OP_BRANCH, 0, 0, 1'b1, 1'b0);  exec("beq_taken", 100, 3);
    build(OP_BRANCH, 0, 0, 1'b0, 1'b0);  exec("beq_not", 100, 3);
    build(OP_JALR, 0, 0, 1'b0, 1'b0);    exec("jalr", 100, 3);
    build(OP_JAL, 1, 0, 1'b1, 1'b0);     exec("jal", 100, 4);
    build(OP_STORE, 0, 0, 1'b0, 1'b0);   exec("store", 100, 4);
    build(OP_ARITH_I, 0, 0, 1'b0, 1'b0); exec("addi", 100, 4);
    build(OP_ZERO, 0, 0, 1'b0, 1'b1);    exec("nop_zero", 100, 2);
    build(OP_ECALL, 0, 0, 1'b0, 1'b0);   exec("ecall_nohalt", 100, 2);
    build(OP_FENCE, 1, 0, 1'b0, 1'b0);   exec("unknown", 100, 3);

    for (int unsigned n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 9)];
      wi = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      bc = rb();
`ifdef ECALL_HALT_EN
      hr = (op == OP_ECALL) ? 1'b0 : rb();
`else
      hr = rb();
`endif
      build(op, wi, wm, bc, hr);
      exec($sformatf("rnd%0d_op%02h", n, op), 100, latency(op, wi, wm));
    end

    build(OP_STORE, 0, 3, 1'b0, 1'b0);
    exec("store_pre_reset", 4, -1);
    #2;
    reset_now("store_reset");
    build(OP_ARITH, 0, 0, 1'b0, 1'b0);   exec("add_after_reset", 100, 4);

`ifdef ECALL_HALT_EN
    build(OP_ECALL, 0, 0, 1'b0, 1'b1);  exec("ecall_halt", 100, 0);
    #2;
    reset_now("halt_reset");
    build(OP_ARITH, 0, 0, 1'b0, 1'b0);   exec("add_after_halt", 100, 4);
`else
    build(OP_ECALL, 0, 0, 1'b0, 1'b1);  exec("ecall_hr_nop", 100, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control_unit.md
# multi_cycle_control_unit

Moore/Mealy FSM that sequences the multi-cycle RV32I datapath through the IF, ID, EX, MEM and WB states. It replaces the single-cycle decode for the multi-cycle core, sits beside the datapath, and drives PC, IR, memory, ALU and register-file enables from the IR opcode. Memory access uses a variable-latency ready handshake. Optionally, it halts the core on ECALL.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  IR[6:0]; valid from ID onward.
- `mem_ready`  in  1  shared memory completes the current access this cycle.
- `bcond`  in  1  branch comparison result from ALU, valid in EX.
- `halt_req`  in  1  datapath flag: x17 == 10.
- `pc_write`  out  1  load PC from `pc_source` mux at clock edge.
- `pc_source`  out  2  0 = ALU result, 1 = PC+4 register, 2 = target adder (PC+imm).
- `npc_write`  out  1  latch ALU result into PC+4 register.
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `ir_write`  out  1  latch memory data into IR.
- `alu_src_a`  out  1  0 = PC, 1 = rs1.
- `alu_src_b`  out  2  0 = rs2, 1 = constant 4, 2 = imm.
- `alu_op`  out  2  0 = ADD, 1 = BRANCH compare, 2 = funct decode.
- `reg_write`  out  1  register-file write enable.
- `mem_to_reg`  out  1  writeback from MDR.
- `pc_to_reg`  out  1  writeback PC+4 (jumps).
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `is_halted`  out  1  core halted.

## Operation
- State encoding: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, HALT = 5. Reset state is IF.
- Unlisted outputs are 0 in every state.
- IF:
  - `mem_read` = 1, `i_or_d` = 0.
  - Stay in IF while `mem_ready` = 0.
  - On `mem_ready` = 1: `ir_write` = 1, go to ID.
- ID:
  - `alu_src_a` = 0, `alu_src_b` = 1, `alu_op` = 0, `npc_write` = 1.
  - ECALL (1110011) with `halt_req` = 1: go to HALT.
  - ECALL without halt, opcode 0000000, or unknown opcode: treat as NOP. Assert `pc_write` = 1, `pc_source` = 0, `instr_done` = 1, go to IF.
  - All other opcodes: go to EX.
- EX:
  - ARITHMETIC (0110011): `alu_src_a` = 1, `alu_src_b` = 0, `alu_op` = 2; go to WB.
  - ARITHMETIC_IMM (0010011): `alu_src_a` = 1, `alu_src_b` = 2, `alu_op` = 2; go to WB.
  - LOAD (0000011) / STORE (0100011): `alu_src_a` = 1, `alu_src_b` = 2, `alu_op` = 0; go to MEM.
  - BRANCH (1100011): `alu_src_a` = 1, `alu_src_b` = 0, `alu_op` = 1, `pc_write` = 1, `pc_source` = `bcond` ? 2 : 1, `instr_done` = 1; go to IF.
  - JAL (1101111): `reg_write` = 1, `pc_to_reg` = 1, `pc_write` = 1, `pc_source` = 2, `instr_done` = 1; go to IF.
  - JALR (1100111): `alu_src_a` = 1, `alu_src_b` = 2, `alu_op` = 0, `reg_write` = 1, `pc_to_reg` = 1, `pc_write` = 1, `pc_source` = 0, `instr_done` = 1; go to IF. The datapath clears the LSB of the target.
- MEM:
  - `i_or_d` = 1; `mem_read` = 1 for LOAD, `mem_write` = 1 for STORE.
  - Hold while `mem_ready` = 0.
  - On `mem_ready` = 1, LOAD goes to WB.
  - On `mem_ready` = 1, STORE asserts `pc_write` = 1, `pc_source` = 1, `instr_done` = 1 and goes to IF.
- WB:
  - `reg_write` = 1, `mem_to_reg` = 1 for LOAD.
  - `pc_write` = 1, `pc_source` = 1, `instr_done` = 1; go to IF.
- HALT:
  - `is_halted` = 1; all other outputs 0.
  - Absorbing state; only reset exits.

## Timing
- While `reset_n` = 0, all outputs are 0 and state is IF. Reset is asynchronous, so a reset asserted mid-MEM drops `mem_write` immediately.
- The first IF cycle is the first rising edge after `reset_n` rises.
- Memory strobes stay stable for the whole wait. `i_or_d`, `mem_read` and `mem_write` do not change while `mem_ready` = 0.
- `mem_ready` is sampled combinationally in the same cycle. Each wait cycle adds one cycle of latency.
- `opcode` is sampled only in ID, EX, MEM and WB. `bcond` is used only in EX; `halt_req` only in ID.
- Latency with zero-wait memory:
  - R-type / I-type: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH / JAL / JALR: 3 cycles.
  - NOP / ECALL without halt: 2 cycles.
- `instr_done` pulses exactly once per instruction, coincident with its final `pc_write`.

## Configuration
- `ECALL_HALT_EN` defined: ECALL with `halt_req` = 1 enters HALT and `is_halted` rises on the following cycle.
- `ECALL_HALT_EN` undefined: `halt_req` is ignored, ECALL is a 2-cycle NOP, HALT is unreachable, and `is_halted` is tied to 0.

## Test plan
- Reset, then ADD (0110011) with `mem_ready` held 1: states IF→ID→EX→WB→IF. `reg_write` = 1 only in the WB cycle. `instr_done` pulses in cycle 4.
- LOAD with `mem_ready` = 0 for 2 cycles in both IF and MEM: 9 total cycles. `mem_read` and `i_or_d` stay stable during waits. `mem_to_reg` = 1 in WB.
- BRANCH with `bcond` = 1, then with `bcond` = 0: `pc_source` = 2, then 1, in EX. 3 cycles each.
- JALR: in EX, `pc_to_reg` = 1, `reg_write` = 1 and `pc_source` = 0 all in the same cycle.
- ECALL with `halt_req` = 1 (`ECALL_HALT_EN` defined): `is_halted` = 1 from cycle 3 and held for 10+ cycles. Then `reset_n` low → `is_halted` = 0 asynchronously. Without the macro: 2-cycle NOP, `is_halted` = 0.
- STORE in MEM with `mem_ready` = 0 and `reset_n` asserted: `mem_write` drops to 0 in the same cycle; after release, state is IF.
